prbs_gen_chk: RTL and testbench

- Parametrised successor to the 8-bit PRBS generator.
- Generator: emits a fixed pattern word n_rep times (preamble), then a DATA_W-bit-per-beat PRBS stream, over a valid/ready handshake.
- Checker: self-synchronising; locks to a looped-back PRBS stream and counts bit errors.
- Placement: drives serdes/link BIST datapaths.

---
 rtl/prbs_gen_chk.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_prbs_gen_chk.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen_chk.sv
// PRBS link BIST block: preamble + PRBS generator over valid/ready, and a
// self-synchronising PRBS checker with lock tracking and saturating bit-error count.
module prbs_gen_chk #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ERR_W      = 32,
    parameter int unsigned LOCK_BEATS = 4,
    parameter int unsigned LOSS_BEATS = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] pattern,
    input  logic [CNT_W-1:0]  n_rep,
    input  logic [CNT_W-1:0]  n_beats,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              clr_err,
    output logic              locked,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int unsigned SW     = 31;
    localparam int unsigned ADV_W  = SW + DATA_W;
    localparam int unsigned POP_W  = $clog2(DATA_W + 1);
    localparam int unsigned SUM_W  = ((ERR_W > POP_W) ? ERR_W : POP_W) + 1;
    localparam int unsigned SYNC_W = $clog2(LOCK_BEATS + 1);
    localparam int unsigned LOSS_W = $clog2(LOSS_BEATS + 1);
    localparam logic [SW-1:0] SEED = '1;

    typedef enum logic [1:0] {G_IDLE, G_PRE, G_PRBS} gen_state_t;
    typedef enum logic {C_HUNT, C_LOCKED} chk_state_t;

    // Register index of the x^ORDER term for each polynomial.
    function automatic logic [4:0] tap_hi(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd6;
            2'd1:    return 5'd14;
            2'd2:    return 5'd22;
            default: return 5'd30;
        endcase
    endfunction

    // Register index of the inner feedback term for each polynomial.
    function automatic logic [4:0] tap_lo(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd5;
            2'd1:    return 5'd13;
            2'd2:    return 5'd17;
            default: return 5'd27;
        endcase
    endfunction

    // Advance DATA_W bits; returns {next_state, predicted_word}. With use_din the
    // register absorbs din (self-sync) instead of its own prediction.
    function automatic logic [ADV_W-1:0] lfsr_adv(
        input logic [SW-1:0]     s_in,
        input logic [1:0]        m,
        input logic [DATA_W-1:0] din,
        input logic              use_din
    );
        logic [SW-1:0]     s;
        logic [DATA_W-1:0] w;
        logic              b;
        logic [4:0]        hi;
        logic [4:0]        lo;
        s  = s_in;
        w  = '0;
        hi = tap_hi(m);
        lo = tap_lo(m);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            b    = s[hi] ^ s[lo];
            w[i] = b;
            s    = {s[SW-2:0], (use_din ? din[i] : b)};
        end
        return {s, w};
    endfunction

    gen_state_t         gen_q, gen_d;
    chk_state_t         chk_q, chk_d;
    logic [1:0]         mode_q, mode_d;
    logic [DATA_W-1:0]  pattern_q, pattern_d;
    logic [CNT_W-1:0]   n_rep_q, n_rep_d;
    logic [CNT_W-1:0]   n_beats_q, n_beats_d;
    logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [SW-1:0]      glfsr_q, glfsr_d;
    logic [SW-1:0]      clfsr_q, clfsr_d;
    logic [SYNC_W-1:0]  sync_q, sync_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic [DATA_W-1:0]  tx_data_d;
    logic               tx_valid_d;
    logic               busy_d;
    logic               locked_d;
    logic [ERR_W-1:0]   err_cnt_d;

    logic               xfer_c;
    logic               start_ok_c;
    logic [ADV_W-1:0]   seed_adv_c;
    logic [ADV_W-1:0]   gen_adv_c;
    logic [ADV_W-1:0]   chk_adv_c;
    logic [POP_W-1:0]   e_c;
    logic [SUM_W-1:0]   err_sum_c;
    logic [ERR_W-1:0]   err_sat_c;

    assign xfer_c     = tx_valid & tx_ready;
    assign seed_adv_c = lfsr_adv(SEED, mode, '0, 1'b0);
    assign gen_adv_c  = lfsr_adv(glfsr_q, mode_q, '0, 1'b0);
    assign chk_adv_c  = lfsr_adv(clfsr_q, mode_q, rx_data, chk_q == C_HUNT);
    assign e_c        = POP_W'($countones(rx_data ^ chk_adv_c[DATA_W-1:0]));
    assign err_sum_c  = SUM_W'(err_cnt) + SUM_W'(e_c);
    assign err_sat_c  = (|err_sum_c[SUM_W-1:ERR_W]) ? '1 : err_sum_c[ERR_W-1:0];

    // Generator next-state: the register always holds the state after the word on tx_data.
    always_comb begin
        gen_d      = gen_q;
        mode_d     = mode_q;
        pattern_d  = pattern_q;
        n_rep_d    = n_rep_q;
        n_beats_d  = n_beats_q;
        rep_cnt_d  = rep_cnt_q;
        beat_cnt_d = beat_cnt_q;
        glfsr_d    = glfsr_q;
        tx_data_d  = tx_data;
        tx_valid_d = tx_valid;
        busy_d     = busy;
        start_ok_c = 1'b0;
        if (stop) begin
            gen_d      = G_IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            rep_cnt_d  = '0;
            beat_cnt_d = '0;
        end else begin
            case (gen_q)
                G_IDLE: begin
                    if (start) begin
                        start_ok_c = 1'b1;
                        mode_d     = mode;
                        pattern_d  = pattern;
                        n_rep_d    = n_rep;
                        n_beats_d  = n_beats;
                        rep_cnt_d  = '0;
                        beat_cnt_d = '0;
                        tx_valid_d = 1'b1;
                        busy_d     = 1'b1;
                        if (n_rep == '0) begin
                            gen_d                = G_PRBS;
                            {glfsr_d, tx_data_d} = seed_adv_c;
                        end else begin
                            gen_d     = G_PRE;
                            glfsr_d   = SEED;
                            tx_data_d = pattern;
                        end
                    end
                end
                G_PRE: begin
                    if (xfer_c) begin
                        if (rep_cnt_q + CNT_W'(1) == n_rep_q) begin
                            gen_d                = G_PRBS;
                            rep_cnt_d            = '0;
                            {glfsr_d, tx_data_d} = gen_adv_c;
                        end else begin
                            rep_cnt_d = rep_cnt_q + CNT_W'(1);
                            tx_data_d = pattern_q;
                        end
                    end
                end
                G_PRBS: begin
                    if (xfer_c) begin
                        if ((n_beats_q != '0) && (beat_cnt_q + CNT_W'(1) == n_beats_q)) begin
                            gen_d      = G_IDLE;
                            tx_valid_d = 1'b0;
                            busy_d     = 1'b0;
                            beat_cnt_d = '0;
                        end else begin
                            beat_cnt_d           = beat_cnt_q + CNT_W'(1);
                            {glfsr_d, tx_data_d} = gen_adv_c;
                        end
                    end
                end
                default: gen_d = G_IDLE;
            endcase
        end
    end

    // Checker next-state: HUNT self-syncs on received bits, LOCKED free-runs and counts.
    always_comb begin
        chk_d     = chk_q;
        clfsr_d   = clfsr_q;
        sync_d    = sync_q;
        loss_d    = loss_q;
        locked_d  = locked;
        err_cnt_d = err_cnt;
        if (start_ok_c) begin
            chk_d    = C_HUNT;
            locked_d = 1'b0;
            sync_d   = '0;
            loss_d   = '0;
        end else if (rx_valid) begin
            clfsr_d = chk_adv_c[ADV_W-1:DATA_W];
            case (chk_q)
                C_HUNT: begin
                    if (e_c == '0) begin
                        if (sync_q + SYNC_W'(1) == SYNC_W'(LOCK_BEATS)) begin
                            chk_d    = C_LOCKED;
                            locked_d = 1'b1;
                            sync_d   = '0;
                            loss_d   = '0;
                        end else begin
                            sync_d = sync_q + SYNC_W'(1);
                        end
                    end else begin
                        sync_d = '0;
                    end
                end
                C_LOCKED: begin
                    err_cnt_d = err_sat_c;
                    if (e_c != '0) begin
                        if (loss_q + LOSS_W'(1) == LOSS_W'(LOSS_BEATS)) begin
                            chk_d    = C_HUNT;
                            locked_d = 1'b0;
                            loss_d   = '0;
                            sync_d   = '0;
                        end else begin
                            loss_d = loss_q + LOSS_W'(1);
                        end
                    end else begin
                        loss_d = '0;
                    end
                end
                default: chk_d = C_HUNT;
            endcase
        end
        if (clr_err) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gen_q      <= G_IDLE;
            chk_q      <= C_HUNT;
            mode_q     <= '0;
            pattern_q  <= '0;
            n_rep_q    <= '0;
            n_beats_q  <= '0;
            rep_cnt_q  <= '0;
            beat_cnt_q <= '0;
            glfsr_q    <= SEED;
            clfsr_q    <= SEED;
            sync_q     <= '0;
            loss_q     <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            err_cnt    <= '0;
        end else begin
            gen_q      <= gen_d;
            chk_q      <= chk_d;
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            n_rep_q    <= n_rep_d;
            n_beats_q  <= n_beats_d;
            rep_cnt_q  <= rep_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            glfsr_q    <= glfsr_d;
            clfsr_q    <= clfsr_d;
            sync_q     <= sync_d;
            loss_q     <= loss_d;
            tx_data    <= tx_data_d;
            tx_valid   <= tx_valid_d;
            busy       <= busy_d;
            locked     <= locked_d;
            err_cnt    <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: vector table, loopback scenarios and randomized runs
// checked against a bit-sequence reference model.
module tb_prbs_gen_chk;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start, stop, tx_ready, clr_err;
    logic [1:0]  mode;
    logic [7:0]  pattern, err_mask;
    logic [15:0] n_rep, n_beats;
    logic [7:0]  tx_data, tx_data2, rx_data;
    logic        tx_valid, tx_valid2, busy, busy2, locked, locked2, rx_valid;
    logic [31:0] err_cnt;
    logic [3:0]  err_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    assign rx_valid = tx_valid & tx_ready;
    assign rx_data  = tx_data ^ err_mask;

    prbs_gen_chk dut (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .mode(mode),
        .pattern(pattern), .n_rep(n_rep), .n_beats(n_beats),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .rx_valid(rx_valid), .rx_data(rx_data), .clr_err(clr_err),
        .locked(locked), .err_cnt(err_cnt)
    );

    prbs_gen_chk #(.ERR_W(4)) dut2 (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .mode(mode),
        .pattern(pattern), .n_rep(n_rep), .n_beats(n_beats),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready), .busy(busy2),
        .rx_valid(rx_valid), .rx_data(rx_data), .clr_err(clr_err),
        .locked(locked2), .err_cnt(err_cnt2)
    );

    // Reference model: generator and checker expressed as bit histories.
    bit         gq[$];
    bit         hq[$];
    bit         m_busy, m_inf, c_locked;
    logic [1:0] m_mode;
    logic [7:0] m_pat, m_cur;
    int         rep_left, beats_left, sync_n, loss_n, n_xfer;
    longint     err1, err2;

    function automatic int ord(input logic [1:0] m);
        case (m)
            2'd0:    return 7;
            2'd1:    return 15;
            2'd2:    return 23;
            default: return 31;
        endcase
    endfunction

    function automatic int tp(input logic [1:0] m);
        case (m)
            2'd0:    return 6;
            2'd1:    return 14;
            2'd2:    return 18;
            default: return 28;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic seed_gen();
        gq.delete();
        for (int i = 0; i < 31; i++) gq.push_back(1'b1);
    endtask

    task automatic model_reset();
        m_busy = 0; m_mode = 2'd0; c_locked = 0;
        sync_n = 0; loss_n = 0; err1 = 0; err2 = 0;
        seed_gen();
        hq.delete();
        for (int i = 0; i < 31; i++) hq.push_back(1'b1);
    endtask

    // Bit n of a PRBS equals bit n-ORDER xor bit n-TAP.
    task automatic gen_word(output logic [7:0] w);
        bit b;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            b = gq[gq.size() - ord(m_mode)] ^ gq[gq.size() - tp(m_mode)];
            w[7 - i] = b;
            gq.push_back(b);
            void'(gq.pop_front());
        end
    endtask

    task automatic chk_beat(input logic [7:0] rxw);
        int e;
        bit p, r;
        e = 0;
        for (int i = 0; i < 8; i++) begin
            p = hq[hq.size() - ord(m_mode)] ^ hq[hq.size() - tp(m_mode)];
            r = rxw[7 - i];
            if (p != r) e++;
            hq.push_back(c_locked ? p : r);
            void'(hq.pop_front());
        end
        if (!c_locked) begin
            if (e == 0) begin
                sync_n++;
                if (sync_n == 4) begin c_locked = 1; sync_n = 0; loss_n = 0; end
            end else sync_n = 0;
        end else begin
            err1 += e;
            if (err1 > 64'h0000_0000_FFFF_FFFF) err1 = 64'h0000_0000_FFFF_FFFF;
            err2 += e;
            if (err2 > 15) err2 = 15;
            if (e != 0) begin
                loss_n++;
                if (loss_n == 4) begin c_locked = 0; loss_n = 0; sync_n = 0; end
            end else loss_n = 0;
        end
    endtask

    // One clock: predict the edge from the driven inputs, advance, compare outputs.
    task automatic step();
        bit beat;
        beat = m_busy && tx_ready;
        if (beat) begin
            chk("tx_data", tx_data, m_cur);
            chk("tx_data2", tx_data2, m_cur);
            chk_beat(m_cur ^ err_mask);
            n_xfer++;
        end
        if (stop) begin
            m_busy = 0;
        end else if (start && !m_busy) begin
            m_busy = 1; m_mode = mode; m_pat = pattern;
            rep_left = n_rep; beats_left = n_beats; m_inf = (n_beats == 0);
            seed_gen();
            if (rep_left > 0) m_cur = m_pat; else gen_word(m_cur);
            c_locked = 0; sync_n = 0; loss_n = 0;
        end else if (beat) begin
            if (rep_left > 0) rep_left--; else if (!m_inf) beats_left--;
            if (rep_left > 0) m_cur = m_pat;
            else if (!m_inf && beats_left == 0) m_busy = 0;
            else gen_word(m_cur);
        end
        if (clr_err) begin err1 = 0; err2 = 0; end
        @(posedge CLK);
        #1;
        start = 0; stop = 0; clr_err = 0; err_mask = '0;
        chk("busy", busy, m_busy);
        chk("tx_valid", tx_valid, m_busy);
        chk("busy2", busy2, m_busy);
        chk("locked", locked, c_locked);
        chk("locked2", locked2, c_locked);
        chk("err_cnt", err_cnt, err1);
        chk("err_cnt2", err_cnt2, err2);
    endtask

    task automatic go(input logic [1:0] md, input logic [7:0] pat,
                      input int rep, input int beats);
        mode = md; pattern = pat; n_rep = 16'(rep); n_beats = 16'(beats);
        start = 1;
        step();
    endtask

    task automatic hard_reset();
        RST = 1;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 0;
    endtask

    typedef struct {
        logic [1:0]  md;
        logic [7:0]  pat;
        int          rep;
        int          beats;
        int          len;
        logic [63:0] ws;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] hold_exp[7];
        bit         hold_rdy[7];
        int         got, n0, sum;
        logic [7:0] msk;

        vecs[0] = '{2'd0, 8'h00, 0, 2, 2, 64'h020C_0000_0000_0000};
        vecs[1] = '{2'd0, 8'hA5, 3, 2, 5, 64'hA5A5_A502_0C00_0000};
        vecs[2] = '{2'd0, 8'h3C, 1, 3, 4, 64'h3C02_0C28_0000_0000};
        vecs[3] = '{2'd1, 8'h00, 0, 2, 2, 64'h0002_0000_0000_0000};
        vecs[4] = '{2'd2, 8'h5A, 0, 3, 3, 64'h0000_3E00_0000_0000};
        vecs[5] = '{2'd3, 8'hFF, 2, 4, 6, 64'hFFFF_0000_000E_0000};
        hold_exp = '{8'hA5, 8'hA5, 8'hA5, 8'h02, 8'h0C, 8'h0C, 8'h0C};
        hold_rdy = '{1, 1, 1, 1, 0, 0, 1};

        RST = 1; start = 0; stop = 0; clr_err = 0; tx_ready = 0; err_mask = '0;
        mode = '0; pattern = '0; n_rep = '0; n_beats = '0; n_xfer = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_err_cnt", err_cnt, 32'd0);
        RST = 0;
        step();

        // Vector table: full word sequences with the sink always ready.
        for (int v = 0; v < 6; v++) begin
            tx_ready = 1;
            go(vecs[v].md, vecs[v].pat, vecs[v].rep, vecs[v].beats);
            got = 0;
            for (int c = 0; c < 40 && got < vecs[v].len; c++) begin
                if (tx_valid) begin
                    chk($sformatf("vec%0d_w%0d", v, got), tx_data, vecs[v].ws[63 - 8*got -: 8]);
                    got++;
                end
                step();
            end
            chk($sformatf("vec%0d_len", v), got, vecs[v].len);
            chk($sformatf("vec%0d_idle", v), tx_valid, 1'b0);
        end

        // Backpressure mid-stream: data held, no beat lost or duplicated.
        tx_ready = 1;
        go(2'd0, 8'hA5, 3, 2);
        for (int k = 0; k < 7; k++) begin
            tx_ready = hold_rdy[k];
            chk($sformatf("hold_%0d", k), tx_data, hold_exp[k]);
            step();
        end
        chk("hold_done", busy, 1'b0);

        // start together with stop is ignored.
        start = 1; stop = 1; step();
        chk("start_stop", busy, 1'b0);

        // Loopback PRBS31 continuous from reset: lock after exactly 4 beats.
        hard_reset();
        tx_ready = 1;
        go(2'd3, 8'h00, 0, 0);
        for (int k = 0; k < 3; k++) step();
        chk("lock_early", locked, 1'b0);
        step();
        chk("lock_4", locked, 1'b1);
        n0 = n_xfer;
        for (int c = 0; c < 4000 && (n_xfer - n0) < 1000; c++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("run1000", n_xfer - n0, 1000);
        chk("run1000_err", err_cnt, 32'd0);
        tx_ready = 0; stop = 1; step();
        chk("stop_valid", tx_valid, 1'b0);

        // Error injection while locked, loss of lock, relock.
        tx_ready = 1;
        go(2'd3, 8'h00, 0, 0);
        for (int c = 0; c < 100 && !c_locked; c++) step();
        chk("relock_hunt", locked, 1'b1);
        err_mask = 8'h2C; step();
        chk("flip3_err", err_cnt, 32'd3);
        chk("flip3_lock", locked, 1'b1);
        step();
        sum = 3;
        for (int k = 0; k < 4; k++) begin
            msk = 8'($urandom_range(1, 255));
            sum += $countones(msk);
            err_mask = msk;
            step();
        end
        chk("loss_lock", locked, 1'b0);
        chk("loss_err", err_cnt, 32'(sum));
        for (int k = 0; k < 3; k++) step();
        chk("relock_early", locked, 1'b0);
        step();
        chk("relock_4", locked, 1'b1);

        // clr_err beats a same-cycle error; small counter saturates.
        err_mask = 8'h01; clr_err = 1; step();
        chk("clr_err", err_cnt, 32'd0);
        step();
        err_mask = 8'hFF; step();
        err_mask = 8'h3F; step();
        chk("pre_sat", err_cnt2, 4'd14);
        step();
        err_mask = 8'h1F; step();
        chk("sat15", err_cnt2, 4'd15);
        chk("nosat19", err_cnt, 32'd19);
        tx_ready = 0; stop = 1; step();

        // Randomized configurations against the model.
        for (int k = 0; k < 10; k++) begin
            tx_ready = 1;
            go(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3),
               $urandom_range(1, 12));
            for (int c = 0; c < 200 && m_busy; c++) begin
                tx_ready = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 9) == 0) err_mask = 8'($urandom);
                step();
            end
            chk("rand_done", busy, 1'b0);
        end

        // Reset during PRBS phase, then a clean restart.
        tx_ready = 1;
        go(2'd0, 8'h00, 0, 10);
        step(); step(); step();
        RST = 1;
        model_reset();
        #1;
        chk("mid_rst_valid", tx_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_data", tx_data, 8'h00);
        chk("mid_rst_locked", locked, 1'b0);
        chk("mid_rst_err", err_cnt, 32'd0);
        @(posedge CLK);
        #1;
        RST = 0;
        tx_ready = 1;
        go(2'd0, 8'h00, 0, 2);
        chk("post_rst_w0", tx_data, 8'h02);
        step();
        chk("post_rst_w1", tx_data, 8'h0C);
        step();
        chk("post_rst_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
